morse_key_decoder: RTL and testbench
====================================

MORSE_KEY_DECODER -- requirements
Module: morse_key_decoder

Interface
REQ-001 The block SHALL have parameter UNIT_CYCLES, default 60000, meaning clock cycles in one Morse time unit (range 2..2^22).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 2400, meaning the consecutive stable cycles required to accept a key change (range 1..65535).
REQ-003 The block SHALL have parameter CNT_W, default 24, meaning the width of the press and gap counters (≥ bits to hold 5*UNIT_CYCLES).
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 key_in  input  1  raw straight-key level, asynchronous, active-high (pressed=1).
REQ-007 key_db_o  output  1  synchronised, debounced key level.
REQ-008 dot_o  output  1  one-cycle pulse, dot recognised; drives the downstream dot input.
REQ-009 dash_o  output  1  one-cycle pulse, dash recognised; drives the downstream dash input.
REQ-010 char_space_o  output  1  one-cycle pulse, character gap recognised; drives the downstream char-space input.
REQ-011 word_space_o  output  1  one-cycle pulse, word gap recognised; drives the downstream word-space input.

Function
REQ-012 key_in SHALL pass through a 2-flop synchroniser before any other logic.
REQ-013 key_db_o SHALL change only after the synchronised key differs from key_db_o for DEBOUNCE_CYCLES consecutive cycles; any shorter disagreement SHALL reset the debounce count.
REQ-014 FSM states SHALL be IDLE, PRESS, GAP, GAP_CHAR; all timing SHALL be measured on key_db_o.
REQ-015 In any state, a rising edge of key_db_o SHALL move to PRESS and clear the press counter.
REQ-016 In PRESS, the press counter SHALL increment each cycle key_db_o=1, saturating at 2^CNT_W-1.
REQ-017 On a falling edge of key_db_o in PRESS, the block SHALL pulse dot_o if press count < 2*UNIT_CYCLES, else dash_o, in the cycle after key_db_o falls, then enter GAP with the gap counter cleared.
REQ-018 dot_o and dash_o SHALL never be asserted in the same cycle, and each SHALL be asserted for exactly one cycle per press.
REQ-019 In GAP, once key_db_o has been low for 2*UNIT_CYCLES cycles, char_space_o SHALL pulse once and the FSM SHALL enter GAP_CHAR.
REQ-020 In GAP_CHAR, once key_db_o has been low for 5*UNIT_CYCLES cycles, counted from the same falling edge, word_space_o SHALL pulse once and the FSM SHALL enter IDLE.
REQ-021 IDLE SHALL emit no pulses regardless of how long the key stays released, so there are no repeated spaces.
REQ-022 The gap counter SHALL saturate and never wrap.
REQ-023 A press starting in GAP SHALL suppress char_space_o; a press starting in GAP_CHAR SHALL suppress word_space_o.
REQ-024 All outputs SHALL be driven directly from flops.

Reset
REQ-025 While rst_n=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and the synchroniser, debounce, press and gap counters SHALL be 0.
REQ-026 Reset asserted mid-press or mid-gap SHALL abort the operation, and no pulse for it SHALL appear after rst_n is released.
REQ-027 If key_in=1 at reset release, key_db_o SHALL rise only after the debounce delay, which is then treated as a new press.

Configuration
REQ-028 Macro MORSE_AUTOSPACE_EN: when defined, the block SHALL generate char_space_o and word_space_o per REQ-019..REQ-023.
REQ-029 When MORSE_AUTOSPACE_EN is undefined, char_space_o and word_space_o SHALL be tied 0, the gap counter SHALL be absent, and the FSM SHALL return to IDLE directly after the dot or dash pulse, leaving the downstream block's manual space buttons as the only source of spaces.

Verification (UNIT_CYCLES=10, DEBOUNCE_CYCLES=4, MORSE_AUTOSPACE_EN defined unless stated)
REQ-030 Reset: hold rst_n=0 with key_in=1, toggle clk -> all outputs 0; release rst_n -> key_db_o rises 6-7 cycles later, with no pulse yet.
REQ-031 Dot and dash: key_db_o high 15 cycles -> one dot_o pulse and no dash_o; key_db_o high 35 cycles -> one dash_o pulse and no dot_o.
REQ-032 Glitch rejection: key_in high for 3 cycles -> key_db_o stays 0 and no pulses occur.
REQ-033 Gap timing: dot, then key low for 80 cycles -> char_space_o pulses 20 cycles and word_space_o pulses 50 cycles after key_db_o falls, each exactly once, then silence.
REQ-034 Interrupted gap and reset: re-press 30 cycles after release -> char_space_o seen, word_space_o never; rst_n pulsed low mid-press at 12 cycles -> no dot_o or dash_o afterwards.
REQ-035 Macro undefined: dot, then key low for 80 cycles -> char_space_o and word_space_o stay 0 throughout.

Source files
------------

// File: rtl/morse_key_decoder.sv
// rtl/morse_key_decoder.sv - straight-key Morse decoder (dot/dash/space pulses); optional auto-spacing via `MORSE_AUTOSPACE_EN
module morse_key_decoder #(
  parameter int UNIT_CYCLES     = 60000,
  parameter int DEBOUNCE_CYCLES = 2400,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_db_o,
  output logic dot_o,
  output logic dash_o,
  output logic char_space_o,
  output logic word_space_o
);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_GAP, S_GAP_CHAR} state_t;

  localparam logic [15:0]      DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOT_LIMIT = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef MORSE_AUTOSPACE_EN
  // Gap counter holds (low cycles - 1) when compared, so thresholds are one below the unit counts
  localparam logic [CNT_W-1:0] CHAR_AT   = CNT_W'(2 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WORD_AT   = CNT_W'(5 * UNIT_CYCLES - 1);
`endif

  logic             r_sync1;
  logic             r_sync2;
  logic [15:0]      r_db_cnt;
  logic             r_key_db;
  logic             r_key_prev;
  state_t           r_state;
  logic [CNT_W-1:0] r_press_cnt;
  logic             r_dot;
  logic             r_dash;
  logic             w_rise;
  logic             w_fall;

  assign w_rise   = r_key_db & ~r_key_prev;
  assign w_fall   = ~r_key_db & r_key_prev;
  assign key_db_o = r_key_db;
  assign dot_o    = r_dot;
  assign dash_o   = r_dash;

  // Two-flop synchroniser for the asynchronous key level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt <= '0;
      r_key_db <= 1'b0;
    end else if (r_sync2 == r_key_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_key_db <= r_sync2;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 16'd1;
    end
  end

`ifdef MORSE_AUTOSPACE_EN
  logic [CNT_W-1:0] r_gap_cnt;
  logic             r_char;
  logic             r_word;
  assign char_space_o = r_char;
  assign word_space_o = r_word;
`else
  assign char_space_o = 1'b0;
  assign word_space_o = 1'b0;
`endif

  // Timing FSM on the debounced key: classifies presses and, optionally, gaps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_key_prev  <= 1'b0;
      r_press_cnt <= '0;
      r_dot       <= 1'b0;
      r_dash      <= 1'b0;
`ifdef MORSE_AUTOSPACE_EN
      r_gap_cnt   <= '0;
      r_char      <= 1'b0;
      r_word      <= 1'b0;
`endif
    end else begin
      r_key_prev <= r_key_db;
      r_dot      <= 1'b0;
      r_dash     <= 1'b0;
`ifdef MORSE_AUTOSPACE_EN
      r_char     <= 1'b0;
      r_word     <= 1'b0;
`endif
      if (w_rise) begin
        // A new press always wins, which also suppresses any pending space
        r_state     <= S_PRESS;
        r_press_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
          end
          S_PRESS: begin
            if (w_fall) begin
              if (r_press_cnt < DOT_LIMIT) r_dot  <= 1'b1;
              else                         r_dash <= 1'b1;
`ifdef MORSE_AUTOSPACE_EN
              // The key has already been low for one cycle at this point
              r_state   <= S_GAP;
              r_gap_cnt <= CNT_ONE;
`else
              r_state   <= S_IDLE;
`endif
            end else if (r_key_db && (r_press_cnt != CNT_MAX)) begin
              r_press_cnt <= r_press_cnt + CNT_ONE;
            end
          end
`ifdef MORSE_AUTOSPACE_EN
          S_GAP: begin
            if (r_gap_cnt != CNT_MAX) r_gap_cnt <= r_gap_cnt + CNT_ONE;
            if (r_gap_cnt == CHAR_AT) begin
              r_char  <= 1'b1;
              r_state <= S_GAP_CHAR;
            end
          end
          S_GAP_CHAR: begin
            if (r_gap_cnt != CNT_MAX) r_gap_cnt <= r_gap_cnt + CNT_ONE;
            if (r_gap_cnt == WORD_AT) begin
              r_word  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
`endif
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// tb/tb_morse_key_decoder.sv - scoreboard bench for morse_key_decoder with a timing reference model
module tb_morse_key_decoder;

  localparam int U   = 10;
  localparam int DB  = 4;
  localparam int LAT = 2 + DB;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic key_in = 1'b1;
  logic key_db, dot, dash, char_sp, word_sp;

  morse_key_decoder #(
    .UNIT_CYCLES(U),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(24)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_in(key_in),
    .key_db_o(key_db),
    .dot_o(dot),
    .dash_o(dash),
    .char_space_o(char_sp),
    .word_space_o(word_sp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  ev_t   exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    pulses = 0;
  int    spaces_seen = 0;
  int    spaces_exp = 0;
  string names[4] = '{"dot", "dash", "char_space", "word_space"};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic void push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    logic [3:0] p;
    ev_t e;
    p = {word_sp, char_sp, dash, dot};
    if (rst_n && (p != 4'b0)) begin
      check("dot_dash_exclusive", {31'b0, dot & dash}, 32'd0);
      for (int k = 0; k < 4; k++) begin
        if (p[k]) begin
          pulses++;
          if (k >= 2) spaces_seen++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pulse_%s: got pulse at cycle %0d want none", names[k], cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.at != cyc) begin
              bad++;
              $display("FAIL pulse_%s: got %s at cycle %0d want %s at cycle %0d",
                       names[k], names[k], cyc, names[e.kind], e.at);
            end
          end
        end
      end
    end
  end

  // Reference model: key_db follows key_in LAT cycles later; a press of h cycles is a dot
  // when shorter than 2 units; spaces fall 2 and 5 units after key_db drops if the gap allows.
  task automatic key_release(input int h, input int g);
    int q;
    key_in = 1'b0;
    q = cyc;
    push((h < 2 * U) ? 0 : 1, q + LAT + 1);
`ifdef MORSE_AUTOSPACE_EN
    if (g > 2 * U) begin
      push(2, q + LAT + 2 * U);
      spaces_exp++;
    end
    if (g > 5 * U) begin
      push(3, q + LAT + 5 * U);
      spaces_exp++;
    end
`endif
    repeat (g) @(posedge clk);
    #1;
  endtask

  task automatic do_press(input int h, input int g);
    key_in = 1'b1;
    repeat (h) @(posedge clk);
    #1;
    key_release(h, g);
  endtask

  initial begin
    int h, g, hi, p0;

    // Reset with key held: everything quiet, then key_db rises after the debounce delay
    repeat (3) @(posedge clk);
    #1;
    check("reset_key_db", {31'b0, key_db}, 32'd0);
    check("reset_dot", {31'b0, dot}, 32'd0);
    check("reset_dash", {31'b0, dash}, 32'd0);
    check("reset_char", {31'b0, char_sp}, 32'd0);
    check("reset_word", {31'b0, word_sp}, 32'd0);
    rst_n = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    check("key_db_before_debounce", {31'b0, key_db}, 32'd0);
    @(posedge clk);
    #1;
    check("key_db_after_debounce", {31'b0, key_db}, 32'd1);
    repeat (25 - LAT) @(posedge clk);
    #1;
    key_release(25, 80);

    // Directed: dot with full gap, dash with interrupted gap, dot with full gap
    do_press(15, 80);
    do_press(35, 30);
    do_press(10, 80);

    // Randomized presses and gaps, kept clear of the classification thresholds
    for (int i = 0; i < 12; i++) begin
      h = ($urandom_range(0, 1) == 0) ? $urandom_range(5, 15) : $urandom_range(25, 60);
      case ($urandom_range(0, 2))
        0:       g = $urandom_range(6, 15);
        1:       g = $urandom_range(25, 45);
        default: g = $urandom_range(55, 80);
      endcase
      do_press(h, g);
    end
    do_press(12, 80);
    check("queue_drained_pre_glitch", exp_q.size(), 32'd0);

    // Glitch shorter than the debounce window
    p0 = pulses;
    hi = 0;
    key_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    key_in = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (key_db) hi++;
    end
    check("glitch_key_db_high_cycles", hi, 32'd0);
    check("glitch_pulses", pulses - p0, 32'd0);

    // Reset 12 cycles into a press aborts it
    p0 = pulses;
    key_in = 1'b1;
    repeat (LAT + 12) @(posedge clk);
    #1;
    rst_n  = 1'b0;
    key_in = 1'b0;
    #1;
    check("midreset_key_db", {31'b0, key_db}, 32'd0);
    check("midreset_dot", {31'b0, dot}, 32'd0);
    check("midreset_dash", {31'b0, dash}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check("midreset_pulses", pulses - p0, 32'd0);

    check("queue_drained", exp_q.size(), 32'd0);
    check("space_count", spaces_seen, spaces_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
